// File: rtl/router_pkg.sv
// router_pkg: shared constants for the router register block.
package router_pkg;
  localparam int DW_DEF = 8;
  localparam logic [1:0] ADDR_INVALID = 2'b11;
endpackage

// File: rtl/router_parity.sv
// router_parity: running XOR of header and payload bytes for the current packet.
module router_parity
  import router_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          clr,
  input  logic          lfd,
  input  logic          ld,
  input  logic          pktvalid,
  input  logic [DW-1:0] header_byte,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] parity
);
  logic [DW-1:0] parity_nxt;
  always_comb
    parity_nxt = clr              ? '0 :
                 lfd              ? parity ^ header_byte :
                 (ld && pktvalid) ? parity ^ din :
                                    parity;
  always_ff @(posedge clk)
    if (!rst) parity <= '0;
    else if (!hold) parity <= parity_nxt;
endmodule

// File: rtl/router_reg.sv
// router_reg: routes packet bytes to the destination FIFO and checks packet parity.
module router_reg
  import router_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pktvalid,
  input  logic [DW-1:0] din,
  input  logic          fifofull,
  input  logic          detectadd,
  input  logic          lfdstate,
  input  logic          ldstate,
  input  logic          fullstate,
  input  logic          lafstate,
  input  logic          rstintreg,
  output logic [DW-1:0] dout,
  output logic          parity_done,
  output logic          low_pkt_valid,
  output logic          err
);
  logic [DW-1:0] header_byte, hold_byte, pkt_parity, parity;
  logic          ld_end;
  assign ld_end = ldstate && !pktvalid;
  router_parity #(.DW(DW)) u_parity (
    .clk(clk),
    .rst(rst),
    .hold(fullstate),
    .clr(detectadd),
    .lfd(lfdstate),
    .ld(ldstate),
    .pktvalid(pktvalid),
    .header_byte(header_byte),
    .din(din),
    .parity(parity)
  );
  // fullstate freezes every register, whatever else is flagged.
  always_ff @(posedge clk)
    if (!rst) begin
      dout          <= '0;
      header_byte   <= '0;
      hold_byte     <= '0;
      pkt_parity    <= '0;
      parity_done   <= 1'b0;
      low_pkt_valid <= 1'b0;
      err           <= 1'b0;
    end else if (!fullstate) begin
      if (detectadd && pktvalid && din[1:0] != ADDR_INVALID) header_byte <= din;
      if (lfdstate) dout <= header_byte;
      else if (ldstate && !fifofull) dout <= din;
      else if (lafstate) dout <= hold_byte;
      if (ldstate && fifofull) hold_byte <= din;
      if (ld_end) pkt_parity <= din;
      if (ld_end) low_pkt_valid <= 1'b1;
      else if (rstintreg) low_pkt_valid <= 1'b0;
      if (detectadd) parity_done <= 1'b0;
      else if ((ld_end && !fifofull) || (lafstate && low_pkt_valid)) parity_done <= 1'b1;
      if (detectadd) err <= 1'b0;
      else if (parity_done) err <= parity != pkt_parity;
    end
endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: directed self-checking bench for router_reg.
module tb_router_reg;
  localparam logic [5:0] NONE = 6'b000000, DA = 6'b100000, LFD = 6'b010000,
                         LD = 6'b001000, FUL = 6'b000100, LAF = 6'b000010, RI = 6'b000001;
  logic clk = 0, rst = 0, pktvalid = 0, fifofull = 0;
  logic detectadd = 0, lfdstate = 0, ldstate = 0, fullstate = 0, lafstate = 0, rstintreg = 0;
  logic [7:0] din = 0, dout;
  logic parity_done, low_pkt_valid, err;
  int nchk = 0, nfail = 0;

  router_reg dut (
    .clk(clk), .rst(rst), .pktvalid(pktvalid), .din(din), .fifofull(fifofull),
    .detectadd(detectadd), .lfdstate(lfdstate), .ldstate(ldstate), .fullstate(fullstate),
    .lafstate(lafstate), .rstintreg(rstintreg), .dout(dout), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [5:0] f, input logic pv, input logic [7:0] d, input logic ff);
    {detectadd, lfdstate, ldstate, fullstate, lafstate, rstintreg} = f;
    pktvalid = pv;
    din = d;
    fifofull = ff;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    step(NONE, 0, 8'h00, 0);
    step(NONE, 0, 8'h00, 0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_pd", {7'd0, parity_done}, 8'h0);
    chk("rst_lpv", {7'd0, low_pkt_valid}, 8'h0);
    chk("rst_err", {7'd0, err}, 8'h0);
    rst = 1;
    // good packet
    step(DA, 1, 8'h05, 0);
    step(LFD, 1, 8'h11, 0);  chk("p1_hdr", dout, 8'h05);
    step(LD, 1, 8'h11, 0);   chk("p1_b1", dout, 8'h11);
    step(LD, 1, 8'h22, 0);   chk("p1_b2", dout, 8'h22);
    step(LD, 0, 8'h36, 0);   chk("p1_par", dout, 8'h36);
    chk("p1_pd", {7'd0, parity_done}, 8'h1);
    chk("p1_lpv", {7'd0, low_pkt_valid}, 8'h1);
    step(RI, 0, 8'h00, 0);
    chk("p1_err", {7'd0, err}, 8'h0);
    chk("p1_lpv_clr", {7'd0, low_pkt_valid}, 8'h0);
    chk("p1_pd_hold", {7'd0, parity_done}, 8'h1);
    // bad parity packet
    step(DA, 1, 8'h05, 0);   chk("p2_pd_clr", {7'd0, parity_done}, 8'h0);
    step(LFD, 1, 8'h11, 0);
    step(LD, 1, 8'h11, 0);
    step(LD, 1, 8'h22, 0);
    step(LD, 0, 8'h37, 0);
    chk("p2_pd", {7'd0, parity_done}, 8'h1);
    chk("p2_err_early", {7'd0, err}, 8'h0);
    step(RI, 0, 8'h00, 0);   chk("p2_err", {7'd0, err}, 8'h1);
    step(NONE, 1, 8'h55, 0); chk("p2_err_hold", {7'd0, err}, 8'h1);
    chk("p2_dout_hold", dout, 8'h37);
    step(DA, 1, 8'h05, 0);   chk("p2_err_clr", {7'd0, err}, 8'h0);
    // fifofull mid-payload
    step(LFD, 1, 8'h11, 0);
    step(LD, 1, 8'h11, 0);
    step(LD, 1, 8'h22, 1);   chk("p3_full_dout", dout, 8'h11);
    step(FUL | LD, 1, 8'h33, 0); chk("p3_fullstate_hold", dout, 8'h11);
    step(LAF, 1, 8'h33, 0);  chk("p3_laf_dout", dout, 8'h22);
    step(LD, 0, 8'h36, 0);   chk("p3_pd", {7'd0, parity_done}, 8'h1);
    step(RI, 0, 8'h00, 0);   chk("p3_err", {7'd0, err}, 8'h0);
    // pktvalid falls while fifo full
    step(DA, 1, 8'h05, 0);
    step(LFD, 1, 8'h11, 0);
    step(LD, 1, 8'h11, 0);
    step(LD, 1, 8'h22, 0);
    step(LD, 0, 8'h36, 1);
    chk("p4_lpv", {7'd0, low_pkt_valid}, 8'h1);
    chk("p4_pd", {7'd0, parity_done}, 8'h0);
    chk("p4_dout", dout, 8'h22);
    step(FUL, 0, 8'h00, 1);
    step(LAF, 0, 8'h00, 0);
    chk("p4_laf_pd", {7'd0, parity_done}, 8'h1);
    chk("p4_laf_dout", dout, 8'h36);
    step(RI, 0, 8'h00, 0);
    chk("p4_lpv_clr", {7'd0, low_pkt_valid}, 8'h0);
    chk("p4_err", {7'd0, err}, 8'h0);
    // invalid address keeps previous header
    step(DA, 1, 8'hFF, 0);
    step(LFD, 0, 8'h00, 0);  chk("p5_hdr_kept", dout, 8'h05);
    // reset mid-packet
    step(DA, 1, 8'h06, 0);
    step(LFD, 1, 8'h11, 0);  chk("p6_hdr", dout, 8'h06);
    step(LD, 1, 8'h11, 0);
    step(LD, 0, 8'h99, 1);   chk("p6_lpv", {7'd0, low_pkt_valid}, 8'h1);
    rst = 0;
    step(LD, 1, 8'h22, 0);
    chk("p6_rst_dout", dout, 8'h00);
    chk("p6_rst_lpv", {7'd0, low_pkt_valid}, 8'h0);
    chk("p6_rst_pd", {7'd0, parity_done}, 8'h0);
    chk("p6_rst_err", {7'd0, err}, 8'h0);
    rst = 1;
    step(DA, 1, 8'h02, 0);
    step(LFD, 1, 8'hAA, 0);  chk("p7_hdr", dout, 8'h02);
    step(LD, 1, 8'hAA, 0);   chk("p7_b1", dout, 8'hAA);
    step(LD, 0, 8'hA8, 0);   chk("p7_pd", {7'd0, parity_done}, 8'h1);
    step(RI, 0, 8'h00, 0);   chk("p7_err", {7'd0, err}, 8'h0);
    step(LAF, 0, 8'h00, 0);  chk("p7_hold_rst", dout, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
